// File: rtl/charlieplex_scanner_pkg.sv
// Shared constants and helpers for the charlieplex scanner and its decoder.
// Provides parameter defaults and the derived-size functions (LED count,
// PWM slot length) so every module computes them identically.
package charlieplex_scanner_pkg;

  localparam int DEFAULT_PINCOUNT     = 4;
  localparam int DEFAULT_PWMBITS      = 4;
  localparam int DEFAULT_BLANK_CYCLES = 2;

  // Every ordered pin pair drives one LED.
  function automatic int led_count(input int pincount);
    return pincount * (pincount - 1);
  endfunction

  // A slot of 2^PWMBITS-1 cycles lets the brightest code fill the whole slot.
  function automatic int slot_len(input int pwmbits);
    return (1 << pwmbits) - 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/charlieplex_scanner_framebuffer.sv
// Double-buffered brightness store for the charlieplex scanner.
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears both banks)
//   wr_en/addr/data   write into the back bank; addresses >= LEDCOUNT ignored
//   toggle            exchange front/back on this edge
//   rd_addr, rd_data  combinational read of the front bank
module charlieplex_scanner_framebuffer #(
  parameter int LEDCOUNT  = 12,
  parameter int INDEXBITS = 4,
  parameter int PWMBITS   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [INDEXBITS-1:0] wr_addr,
  input  logic [PWMBITS-1:0]   wr_data,
  input  logic                 toggle,
  input  logic [INDEXBITS-1:0] rd_addr,
  output logic [PWMBITS-1:0]   rd_data
);

  logic [PWMBITS-1:0] bank0 [LEDCOUNT];
  logic [PWMBITS-1:0] bank1 [LEDCOUNT];
  logic               front;

  // The write uses the pre-toggle front, so a write coinciding with a swap
  // lands in the bank that is about to be displayed.
  always_ff @(posedge clk) begin
    if (rst) begin
      front <= 1'b0;
      for (int i = 0; i < LEDCOUNT; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else begin
      if (wr_en && (int'(wr_addr) < LEDCOUNT)) begin
        if (front) bank0[wr_addr] <= wr_data;
        else       bank1[wr_addr] <= wr_data;
      end
      if (toggle) front <= ~front;
    end
  end

  assign rd_data = front ? bank1[rd_addr] : bank0[rd_addr];

endmodule

// File: rtl/charlieplex_scanner.sv
// Time-multiplexed scan controller for a charlieplexed LED matrix.
// Drives one LED at a time (blank gap, then PWM on-time) from a
// double-buffered brightness framebuffer; feeds an external charlieplexer.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   run                scan enable level
//   wr_en/addr/data    back-bank brightness write
//   swap, swap_ack     bank exchange request / pulse when it takes effect
//   frame_start        pulse in the first blank cycle of LED 0
//   led_index          LED to address (charlieplexer.in)
//   led_enable         LED drive enable (charlieplexer.enable)
//
// state  | meaning
// IDLE   | not scanning, outputs off, counters cleared
// BLANK  | LED addressed but off, BLANK_CYCLES long
// ON     | PWM slot, SLOT cycles, enabled for the first brightness cycles
module charlieplex_scanner
  import charlieplex_scanner_pkg::*;
#(
  parameter  int PINCOUNT     = DEFAULT_PINCOUNT,
  parameter  int PWMBITS      = DEFAULT_PWMBITS,
  parameter  int BLANK_CYCLES = DEFAULT_BLANK_CYCLES,
  localparam int LEDCOUNT     = led_count(PINCOUNT),
  localparam int INDEXBITS    = $clog2(LEDCOUNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 wr_en,
  input  logic [INDEXBITS-1:0] wr_addr,
  input  logic [PWMBITS-1:0]   wr_data,
  input  logic                 swap,
  output logic                 swap_ack,
  output logic                 frame_start,
  output logic [INDEXBITS-1:0] led_index,
  output logic                 led_enable
);

  localparam int SLOT    = slot_len(PWMBITS);
  localparam int CNTBITS = $clog2(max2(BLANK_CYCLES, SLOT) + 1);

  localparam logic [CNTBITS-1:0]   BLANK_LOAD = CNTBITS'(BLANK_CYCLES - 1);
  localparam logic [CNTBITS-1:0]   SLOT_LOAD  = CNTBITS'(SLOT - 1);
  localparam logic [INDEXBITS-1:0] LAST_LED   = INDEXBITS'(LEDCOUNT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ON} state_t;

  state_t               state, state_n;
  logic [CNTBITS-1:0]   cnt, cnt_n;
  logic [PWMBITS-1:0]   en_left, en_left_n;
  logic [INDEXBITS-1:0] idx_n;
  logic                 enable_n, frame_start_n;
  logic                 pending, apply;
  logic [PWMBITS-1:0]   rd_data;

  charlieplex_scanner_framebuffer #(
    .LEDCOUNT (LEDCOUNT),
    .INDEXBITS(INDEXBITS),
    .PWMBITS  (PWMBITS)
  ) u_fb (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .toggle (apply),
    .rd_addr(led_index),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      en_left     <= '0;
      led_index   <= '0;
      led_enable  <= 1'b0;
      frame_start <= 1'b0;
      swap_ack    <= 1'b0;
      pending     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      en_left     <= en_left_n;
      led_index   <= idx_n;
      led_enable  <= enable_n;
      frame_start <= frame_start_n;
      swap_ack    <= apply;
      pending     <= apply ? 1'b0 : (pending | swap);
    end
  end

  // en_left counts the remaining lit cycles of the slot; it is loaded with the
  // front-bank brightness on entry to ON, which also freezes it for the slot.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    en_left_n     = en_left;
    idx_n         = led_index;
    enable_n      = 1'b0;
    frame_start_n = 1'b0;
    apply         = 1'b0;

    unique case (state)
      S_IDLE: begin
        idx_n     = '0;
        cnt_n     = '0;
        en_left_n = '0;
        apply     = pending | swap;
        if (run) begin
          state_n       = S_BLANK;
          cnt_n         = BLANK_LOAD;
          frame_start_n = 1'b1;
        end
      end
      S_BLANK: begin
        if (cnt == '0) begin
          state_n   = S_ON;
          cnt_n     = SLOT_LOAD;
          en_left_n = rd_data;
          enable_n  = (rd_data != '0);
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_ON: begin
        if (cnt == '0) begin
          state_n   = S_BLANK;
          cnt_n     = BLANK_LOAD;
          en_left_n = '0;
          if (led_index == LAST_LED) begin
            idx_n         = '0;
            frame_start_n = 1'b1;
            apply         = pending | swap;
          end else begin
            idx_n = led_index + 1'b1;
          end
        end else begin
          cnt_n     = cnt - 1'b1;
          en_left_n = (en_left != '0) ? en_left - 1'b1 : '0;
          enable_n  = (en_left_n != '0);
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Dropping run overrides the scan; a pending swap survives into IDLE.
    if (state != S_IDLE && !run) begin
      state_n       = S_IDLE;
      idx_n         = '0;
      cnt_n         = '0;
      en_left_n     = '0;
      enable_n      = 1'b0;
      frame_start_n = 1'b0;
      apply         = 1'b0;
    end
  end

endmodule

// File: tb/tb_charlieplex_scanner.sv
module tb_charlieplex_scanner;

  localparam int LEDS  = 12;
  localparam int SLOTC = 15;
  localparam int BLNK  = 2;
  localparam int PER   = BLNK + SLOTC;
  localparam int FRAME = LEDS * PER;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       swap = 1'b0;
  logic       swap_ack, frame_start, led_enable;
  logic [3:0] led_index;

  charlieplex_scanner dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .swap       (swap),
    .swap_ack   (swap_ack),
    .frame_start(frame_start),
    .led_index  (led_index),
    .led_enable (led_enable)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int   stamp;
    logic fs;
    logic ack;
    logic en;
    int   idx;
  } exp_t;
  exp_t sb[$];

  // Reference model: scan position within the frame plus two brightness arrays.
  bit m_run = 0;
  int m_t = 0;
  bit m_pending = 0;
  int disp[LEDS];
  int staged[LEDS];
  bit m_last_en = 0;

  task automatic model_step(input logic r, input logic ru, input logic we,
                            input int a, input int d, input logic sw);
    bit   apply;
    int   slot, w, tmp;
    exp_t e;
    if (r) begin
      m_run = 0; m_t = 0; m_pending = 0; m_last_en = 0;
      for (int i = 0; i < LEDS; i++) begin disp[i] = 0; staged[i] = 0; end
      return;
    end
    apply = 0;
    if (!m_run) begin
      if (m_pending || sw) apply = 1;
      if (ru) begin m_run = 1; m_t = 0; end
    end else if (!ru) begin
      m_run = 0;
    end else begin
      m_t++;
      if (m_t == FRAME) begin
        m_t = 0;
        if (m_pending || sw) apply = 1;
      end
    end
    if (we && a < LEDS) staged[a] = d;
    if (apply) begin
      for (int i = 0; i < LEDS; i++) begin tmp = disp[i]; disp[i] = staged[i]; staged[i] = tmp; end
      m_pending = 0;
    end else if (sw) begin
      m_pending = 1;
    end
    e.stamp = cyc + 1; e.ack = apply; e.fs = 0; e.en = 0; e.idx = 0;
    if (m_run) begin
      slot  = m_t / PER;
      w     = m_t % PER;
      e.idx = slot;
      e.fs  = (m_t == 0);
      e.en  = (w >= BLNK) && ((w - BLNK) < disp[slot]);
    end
    m_last_en = e.en;
    if (e.fs || e.ack || e.en) sb.push_back(e);
  endtask

  task automatic tick(input logic r, input logic ru, input logic we,
                      input int a, input int d, input logic sw);
    rst = r; run = ru; wr_en = we;
    wr_addr = 4'(a); wr_data = 4'(d); swap = sw;
    model_step(r, ru, we, a, d, sw);
    @(negedge clk);
  endtask

  task automatic idle_run(input int n);
    for (int i = 0; i < n; i++) tick(0, 1, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, want);
    end
  endtask

  initial begin
    logic ru;
    int   guard;

    fork
      forever begin
        @(negedge clk);
        if (frame_start || swap_ack || led_enable) begin
          checks++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_output cyc=%0d got fs=%b ack=%b en=%b idx=%0d, expected nothing",
                     cyc, frame_start, swap_ack, led_enable, led_index);
          end else begin
            exp_t e;
            e = sb.pop_front();
            if (e.stamp != cyc || e.fs != frame_start || e.ack != swap_ack ||
                e.en != led_enable || e.idx != int'(led_index)) begin
              fails++;
              $display("FAIL output_event cyc=%0d got fs=%b ack=%b en=%b idx=%0d, expected cyc=%0d fs=%b ack=%b en=%b idx=%0d",
                       cyc, frame_start, swap_ack, led_enable, led_index,
                       e.stamp, e.fs, e.ack, e.en, e.idx);
            end
          end
        end
      end
    join_none

    @(negedge clk);
    for (int i = 0; i < 3; i++) tick(1, 1, 1, 2, 9, 1);
    chk("reset_led_enable", led_enable, 0);
    chk("reset_led_index", led_index, 0);
    chk("reset_swap_ack", swap_ack, 0);
    chk("reset_frame_start", frame_start, 0);

    // All-zero framebuffer: only frame_start events over two frames.
    idle_run(2 * FRAME + 5);

    // LED5 = 15 then swap; visible from the next frame.
    tick(0, 1, 1, 5, 15, 0);
    tick(0, 1, 0, 0, 0, 1);
    idle_run(3 * FRAME);

    // LED3 = 7 without swap, then swap.
    tick(0, 1, 1, 3, 7, 0);
    idle_run(FRAME);
    tick(0, 1, 0, 0, 0, 1);
    tick(0, 1, 0, 0, 0, 1);
    idle_run(2 * FRAME);

    // Out-of-range write then swap.
    tick(0, 1, 1, 12, 9, 0);
    tick(0, 1, 1, 13, 4, 0);
    tick(0, 1, 0, 0, 0, 1);
    idle_run(2 * FRAME);

    // Drop run in the middle of an enabled slot.
    guard = 0;
    while (!m_last_en && guard < 2 * FRAME) begin tick(0, 1, 0, 0, 0, 0); guard++; end
    chk("reached_on_slot", int'(m_last_en), 1);
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    chk("run_drop_led_enable", led_enable, 0);
    chk("run_drop_led_index", led_index, 0);
    tick(0, 0, 1, 7, 11, 0);
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0);
    idle_run(FRAME + 20);

    // Swap pending while running, then drop run: applied from IDLE.
    tick(0, 1, 1, 0, 5, 1);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    idle_run(FRAME + 10);

    // Reset mid-frame with a swap pending.
    tick(0, 1, 1, 1, 9, 0);
    tick(0, 1, 0, 0, 0, 1);
    idle_run(5);
    tick(1, 1, 0, 0, 0, 0);
    chk("midrst_led_enable", led_enable, 0);
    chk("midrst_led_index", led_index, 0);
    chk("midrst_swap_ack", swap_ack, 0);
    chk("midrst_frame_start", frame_start, 0);
    idle_run(2 * FRAME);
    tick(0, 1, 0, 0, 0, 1);
    idle_run(2 * FRAME);

    // Randomized traffic.
    ru = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 299) == 0) ru = ~ru;
      tick($urandom_range(0, 1999) == 0, ru, $urandom_range(0, 3) == 0,
           int'($urandom_range(0, 13)), int'($urandom_range(0, 15)),
           $urandom_range(0, 149) == 0);
    end

    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 0, 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
